// File: rtl/cal_tpsram_reader.sv
// ----------------------------------------------------------------------------
// cal_tpsram_reader
//   Read-side controller for the calibration two-port SRAM (single clock).
//   A START pulse launches LEN sequential reads from BASE_ADDR (address wraps
//   modulo 2^AW). The RAM read latency is absorbed by a tag delay line and a
//   small output FIFO, and the words leave as a valid/ready stream.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_start      1-cycle start pulse, sampled only when idle
//   i_abort      level; terminates the transfer and flushes the FIFO
//   i_base_addr  first read address, captured on start
//   i_len        word count 1..2^AW, captured on start (0 = no-op)
//   o_r_addr     RAM read address
//   i_r_data     RAM read data, valid RD_LAT cycles after o_r_addr
//   o_m_data     stream data
//   o_m_valid    stream valid
//   i_m_ready    stream ready
//   o_m_last     high with the final word of the transfer
//   o_busy       high from accepted start until done
//   o_done       1-cycle pulse when the transfer or abort completes
// ----------------------------------------------------------------------------
module cal_tpsram_reader #(
    parameter int DW     = 38,
    parameter int AW     = 9,
    parameter int RD_LAT = 2,
    parameter int FDEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_len,
    output logic [AW-1:0] o_r_addr,
    input  logic [DW-1:0] i_r_data,
    output logic [DW-1:0] o_m_data,
    output logic          o_m_valid,
    input  logic          i_m_ready,
    output logic          o_m_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam int OW = $clog2(FDEPTH + RD_LAT + 2) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_remain;      // reads still to be issued
    logic            r_busy;
    logic            r_done;
    logic            r_aborted;
    // Bit 0: read on o_r_addr this cycle; bit RD_LAT: matching word on i_r_data now.
    logic [RD_LAT:0] r_pipe_vld;
    logic [RD_LAT:0] r_pipe_last;

    logic [DW:0]     r_fifo_mem [FDEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_m_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_start_go;
    logic            w_issue;
    logic            w_new_last;
    logic            w_pipe_empty;
    logic            w_drain_ok;
    logic [OW-1:0]   w_inflight;
    logic [OW-1:0]   w_fill;
    logic [DW:0]     w_head;

    // Reads issued but whose data has not yet reached i_r_data.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OW'(r_pipe_vld[i]);
        end
    end

    assign w_m_valid    = (r_count != '0);
    assign w_pop        = w_m_valid & i_m_ready;
    assign w_flush      = i_abort & (r_state != ST_IDLE);
    assign w_push       = r_pipe_vld[RD_LAT] & ~r_aborted & ~w_flush;
    assign w_start_go   = (r_state == ST_IDLE) & i_start & (i_len != '0);
    assign w_pipe_empty = (r_pipe_vld == '0);

    // Credit: in-flight reads plus FIFO occupancy after this edge's push/pop
    // must leave room for one more word, so the FIFO can never overflow.
    assign w_fill  = w_inflight + OW'(r_count) + OW'(w_push) - OW'(w_pop);
    assign w_issue = (r_state == ST_RUN) & ~w_flush & (w_fill < OW'(FDEPTH));

    assign w_new_last = w_start_go ? (i_len == LEN_ONE) : (w_issue & (r_remain == LEN_ONE));

    // Normal completion: nothing in flight and the FIFO empties on this edge.
    assign w_drain_ok = w_pipe_empty &
                        ((r_count == '0) || ((r_count == CW'(1)) && w_pop));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_pipe_vld  <= {r_pipe_vld[RD_LAT-1:0], w_start_go | w_issue};
            r_pipe_last <= {r_pipe_last[RD_LAT-1:0], w_new_last};

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            r_addr    <= i_base_addr;
                            r_remain  <= i_len - LEN_ONE;
                            r_busy    <= 1'b1;
                            r_aborted <= 1'b0;
                            r_state   <= (i_len == LEN_ONE) ? ST_DRAIN : ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_flush) begin
                        r_aborted <= 1'b1;
                        r_state   <= ST_DRAIN;
                    end else if (w_issue) begin
                        r_addr   <= r_addr + AW'(1);
                        r_remain <= r_remain - LEN_ONE;
                        if (r_remain == LEN_ONE) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_flush && !r_aborted) begin
                        r_aborted <= 1'b1;
                    end else if (r_aborted ? w_pipe_empty : w_drain_ok) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage carries no reset; the outputs are gated by valid instead.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_pipe_last[RD_LAT], i_r_data};
        end
    end

    assign w_head    = r_fifo_mem[r_rd_ptr];
    assign o_r_addr  = r_addr;
    assign o_m_valid = w_m_valid;
    assign o_m_data  = w_m_valid ? w_head[DW-1:0] : '0;
    assign o_m_last  = w_m_valid & w_head[DW];
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_cal_tpsram_reader.sv
// ----------------------------------------------------------------------------
// tb_cal_tpsram_reader
//   Self-checking bench: a latency-2 RAM model preloaded with random words,
//   randomized ready patterns, and a queue of expected words derived from
//   BASE/LEN arithmetic.
// ----------------------------------------------------------------------------
module tb_cal_tpsram_reader;

    localparam int DW    = 38;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len_in;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    cal_tpsram_reader #(
        .DW     (DW),
        .AW     (AW),
        .RD_LAT (2),
        .FDEPTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_base_addr (base_addr),
        .i_len       (len_in),
        .o_r_addr    (r_addr),
        .i_r_data    (r_data),
        .o_m_data    (m_data),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_last    (m_last),
        .o_busy      (busy),
        .o_done      (done)
    );

    // RAM with address register and output register: data two cycles after address.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_a_q;
    logic [DW-1:0] ram_d_q;
    always @(posedge clk) begin
        ram_a_q <= r_addr;
        ram_d_q <= ram[ram_a_q];
    end
    assign r_data = ram_d_q;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [DW:0] exp_q[$];
    int          exp_total;
    int          n_rx;
    int          last_cnt;
    logic        prev_stall;
    logic [DW-1:0] prev_data;
    logic        prev_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 3) == 0);
            2:       return ($urandom_range(0, 3) != 0);
            3:       return (k > 20);
            default: return 1'b1;
        endcase
    endfunction

    // Stream monitor, called once per cycle at the falling edge.
    task automatic sample_stream();
        logic [DW:0] e;
        if (prev_stall) begin
            check_eq("hold_valid", m_valid, 1'b1);
            check_eq("hold_data", m_data, prev_data);
            check_eq("hold_last", m_last, prev_last);
        end
        if (m_valid && m_last) last_cnt++;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("word_count", n_rx + 1, exp_total);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", m_data, e[DW-1:0]);
                check_eq("last", m_last, e[DW]);
            end
            n_rx++;
        end
        prev_stall = m_valid && !m_ready && !abort;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    // One transfer: abort_after >= 0 aborts once that many words arrived,
    // reset_at >= 0 pulls reset in that cycle, exp_done >= 0 checks DONE cycle.
    task automatic run_xfer(input logic [AW-1:0] t_base, input int t_len, input int mode,
                            input int abort_after, input int reset_at, input int exp_done);
        int   done_k   = -1;
        int   first_v  = -1;
        int   abort_k  = -1;
        int   ndone    = 0;
        logic busy_at1 = 1'b0;
        logic aborted  = 1'b0;
        logic spare;
        logic [AW-1:0] a;
        int   bound;

        exp_q.delete();
        for (int i = 0; i < t_len; i++) begin
            a = t_base + AW'(i);
            exp_q.push_back({(i == t_len - 1), ram[a]});
        end
        exp_total  = t_len;
        n_rx       = 0;
        last_cnt   = 0;
        prev_stall = 1'b0;
        spare      = (abort_after < 0) && (reset_at < 0) && (t_len >= 8);
        bound      = 4 * t_len + 100;

        base_addr = t_base;
        len_in    = (AW+1)'(t_len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        for (int k = 1; k <= bound; k++) begin
            m_ready = ready_for(mode, k);
            if (aborted && k == abort_k + 1) begin
                abort = 1'b0;
                exp_q.delete();
                exp_total = n_rx;
            end
            if (abort_after >= 0 && !aborted && n_rx >= abort_after) begin
                abort   = 1'b1;
                aborted = 1'b1;
                abort_k = k;
            end
            // A second START mid-transfer must be ignored.
            if (spare && k == 6) begin
                start     = 1'b1;
                base_addr = ~t_base;
                len_in    = (AW+1)'(3);
            end
            if (spare && k == 7) start = 1'b0;
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("reset_outputs", {r_addr, m_data, m_valid, m_last, busy, done}, '0);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("no_done_in_reset", {done, busy}, 2'b00);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end

            @(negedge clk);
            sample_stream();
            if (k == 1) busy_at1 = busy;
            if (aborted && k == abort_k + 1) check_eq("abort_valid_drop", m_valid, 1'b0);
            if (mode == 3 && k == 20) begin
                check_eq("stall_raddr", r_addr, t_base + AW'(3));
                check_eq("stall_valid", m_valid, 1'b1);
                check_eq("stall_rx", n_rx, 0);
            end
            if (m_valid && first_v < 0) first_v = k;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 1) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end

        abort = 1'b0;
        check_eq("done_seen", (done_k >= 0), 1'b1);
        if (exp_done >= 0) check_eq("done_cycle", done_k, exp_done);
        check_eq("done_pulses", ndone, 1);
        check_eq("first_valid", first_v, 4);
        check_eq("busy_during", busy_at1, 1'b1);
        check_eq("busy_after", busy, 1'b0);
        if (abort_after >= 0) begin
            check_eq("abort_no_last", last_cnt, 0);
        end else begin
            check_eq("words_rx", n_rx, t_len);
            check_eq("words_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'({$urandom(), $urandom()});
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        len_in    = '0;
        m_ready   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_raddr", r_addr, 0);
        check_eq("rst_stream", {m_data, m_valid, m_last}, 0);
        check_eq("rst_busy_done", {busy, done}, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LEN=0: DONE pulse next cycle, BUSY never rises.
        len_in = '0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("len0_done", done, 1'b1);
        check_eq("len0_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("len0_done_pulse", done, 1'b0);
        @(posedge clk);
        #1;

        run_xfer(9'd0, 512, 0, -1, -1, 516);     // full sweep, ready high
        run_xfer(9'd510, 4, 0, -1, -1, 8);       // address wrap
        run_xfer(9'd37, 8, 1, -1, -1, -1);       // ready 1-of-3
        run_xfer(9'd200, 16, 3, -1, -1, -1);     // ready low 20 cycles
        run_xfer(9'd300, 64, 0, 5, -1, -1);      // abort after 5 words
        run_xfer(9'd100, 2, 0, -1, -1, 6);       // normal after abort
        run_xfer(9'd511, 1, 0, -1, -1, 5);       // single word
        for (int t = 0; t < 6; t++) begin
            run_xfer(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 40),
                     (t % 2 == 0) ? 2 : 0, -1, -1, -1);
        end
        run_xfer(9'd50, 64, 0, -1, 10, -1);      // reset mid-transfer
        run_xfer(9'd7, 12, 2, -1, -1, -1);       // recovery after reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
